intadd_result_collector: RTL and testbench

//  Downstream consumer of the intadd SIMD adder outputs (dst_reg0, dst_reg1, st).

---
 rtl/intadd_result_collector.sv | 174 +++++++++++++++++
 tb/tb_intadd_result_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/intadd_result_collector.sv
// intadd_result_collector
//   Collects intadd SIMD adder results into a DEPTH-entry FIFO and serialises
//   each entry onto a valid/ready writeback port:
//     - 32-bit mode  : one beat (dst0)
//     - 4+8-bit mode : two beats (dst0, then dst1)
//   Also keeps sticky per-lane status bits and a sticky drop error.
//   Optional build macro INTADD_COLL_PERF_EN adds saturating performance
//   counters (results accepted, results dropped, writeback handshakes).
module intadd_result_collector #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic              res_mode,
  input  logic [DATA_W-1:0] res_dst0,
  input  logic [DATA_W-1:0] res_dst1,
  input  logic [DATA_W-1:0] res_st,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_st,
  output logic              wb_beat,
  output logic              wb_last,
  output logic [CW-1:0]     fifo_cnt,
  output logic              fifo_full,
  output logic [11:0]       sticky_st,
  input  logic              sticky_clr,
  output logic              drop_err
`ifdef INTADD_COLL_PERF_EN
  ,
  output logic [31:0]       perf_res_cnt,
  output logic [15:0]       perf_drop_cnt,
  output logic [31:0]       perf_beat_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] out_dst1;

  logic              mem_mode [DEPTH];
  logic [DATA_W-1:0] mem_dst0 [DEPTH];
  logic [DATA_W-1:0] mem_dst1 [DEPTH];
  logic [DATA_W-1:0] mem_st   [DEPTH];

  logic        hs;
  logic        pop;
  logic        push;
  logic        drop;
  logic [11:0] st_bits;

  // A pop refills the output registers: from IDLE, or on the final beat of the
  // current entry so back-to-back entries stream without a bubble. A push into
  // a full FIFO is still accepted when a pop frees a slot at the same edge.
  assign hs        = wb_valid & wb_ready;
  assign pop       = (fifo_cnt != '0) & ((state == IDLE) | (hs & wb_last));
  assign push      = res_valid & (~fifo_full | pop);
  assign drop      = res_valid & ~push;
  assign fifo_full = (fifo_cnt == CW'(DEPTH));

  // Extract the three status bits of each 32-bit lane; only 32-bit mode
  // results contribute to the sticky status.
  always_comb begin
    st_bits = '0;
    if (res_valid && res_mode) begin
      for (int k = 0; k < 4; k++) begin
        st_bits[3*k +: 3] = res_st[32*k +: 3];
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; pointers and fifo_cnt
  // define which entries are valid, so clearing the data would only add logic.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_mode[wr_ptr] <= res_mode;
      mem_dst0[wr_ptr] <= res_dst0;
      mem_dst1[wr_ptr] <= res_dst1;
      mem_st[wr_ptr]   <= res_st;
    end
  end

  // FIFO pointers/occupancy and the writeback FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_st    <= '0;
      wb_beat  <= 1'b0;
      wb_last  <= 1'b0;
      out_dst1 <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);

      if (pop) begin
        state    <= BEAT0;
        wb_valid <= 1'b1;
        wb_data  <= mem_dst0[rd_ptr];
        wb_st    <= mem_st[rd_ptr];
        wb_beat  <= 1'b0;
        wb_last  <= mem_mode[rd_ptr];
        out_dst1 <= mem_dst1[rd_ptr];
      end else begin
        case (state)
          BEAT0: begin
            if (hs) begin
              if (!wb_last) begin
                state   <= BEAT1;
                wb_data <= out_dst1;
                wb_beat <= 1'b1;
                wb_last <= 1'b1;
              end else begin
                state    <= IDLE;
                wb_valid <= 1'b0;
              end
            end
          end
          BEAT1: begin
            if (hs) begin
              state    <= IDLE;
              wb_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sticky lane status and drop error; a clear at the same edge as an
  // update keeps only that edge's new contribution.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_st <= '0;
      drop_err  <= 1'b0;
    end else if (sticky_clr) begin
      sticky_st <= st_bits;
      drop_err  <= drop;
    end else begin
      sticky_st <= sticky_st | st_bits;
      drop_err  <= drop_err | drop;
    end
  end

`ifdef INTADD_COLL_PERF_EN
  // Saturating performance counters, cleared together with the sticky status.
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) begin
      perf_res_cnt  <= '0;
      perf_drop_cnt <= '0;
      perf_beat_cnt <= '0;
    end else begin
      if (push && perf_res_cnt  != '1) perf_res_cnt  <= perf_res_cnt  + 1'b1;
      if (drop && perf_drop_cnt != '1) perf_drop_cnt <= perf_drop_cnt + 1'b1;
      if (hs   && perf_beat_cnt != '1) perf_beat_cnt <= perf_beat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_intadd_result_collector.sv
// tb_intadd_result_collector
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a transaction-level reference model (entry queue + current entry).
module tb_intadd_result_collector;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid;
  logic         res_mode;
  logic [127:0] res_dst0;
  logic [127:0] res_dst1;
  logic [127:0] res_st;
  logic         wb_valid;
  logic         wb_ready;
  logic [127:0] wb_data;
  logic [127:0] wb_st;
  logic         wb_beat;
  logic         wb_last;
  logic [2:0]   fifo_cnt;
  logic         fifo_full;
  logic [11:0]  sticky_st;
  logic         sticky_clr;
  logic         drop_err;

  intadd_result_collector #(.DEPTH(DEPTH), .DATA_W(128)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_mode(res_mode),
    .res_dst0(res_dst0), .res_dst1(res_dst1), .res_st(res_st),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_st(wb_st), .wb_beat(wb_beat), .wb_last(wb_last),
    .fifo_cnt(fifo_cnt), .fifo_full(fifo_full),
    .sticky_st(sticky_st), .sticky_clr(sticky_clr), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic         mode;
    logic [127:0] d0;
    logic [127:0] d1;
    logic [127:0] st;
  } ent_t;

  ent_t        q[$];
  ent_t        cur;
  bit          cur_v;
  bit          cur_b;
  logic [11:0] m_sticky;
  bit          m_drop;

  function automatic logic [11:0] lane_bits(input logic [127:0] st);
    logic [11:0] r;
    for (int k = 0; k < 4; k++) r[3*k +: 3] = st[32*k +: 3];
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs applied before it.
  task automatic model_edge();
    bit          hs, done, pop, accept;
    logic [11:0] nb;
    ent_t        e;
    if (rst) begin
      q.delete();
      cur_v    = 0;
      cur_b    = 0;
      m_sticky = '0;
      m_drop   = 0;
      return;
    end
    hs     = cur_v && wb_ready;
    done   = hs && (cur.mode || cur_b);
    pop    = (q.size() > 0) && (!cur_v || done);
    accept = res_valid && (q.size() < DEPTH || pop);
    if (pop) begin
      cur   = q.pop_front();
      cur_v = 1;
      cur_b = 0;
    end else if (hs) begin
      if (done) cur_v = 0;
      else      cur_b = 1;
    end
    if (accept) begin
      e.mode = res_mode; e.d0 = res_dst0; e.d1 = res_dst1; e.st = res_st;
      q.push_back(e);
    end
    nb = (res_valid && res_mode) ? lane_bits(res_st) : 12'h000;
    if (sticky_clr) begin
      m_sticky = nb;
      m_drop   = res_valid && !accept;
    end else begin
      m_sticky = m_sticky | nb;
      m_drop   = m_drop | (res_valid && !accept);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("wb_valid", wb_valid, cur_v);
    if (cur_v) begin
      check("wb_data", wb_data, cur_b ? cur.d1 : cur.d0);
      check("wb_st",   wb_st,   cur.st);
      check("wb_beat", wb_beat, cur_b);
      check("wb_last", wb_last, cur.mode | cur_b);
    end
    check("fifo_cnt",  fifo_cnt,  q.size());
    check("fifo_full", fifo_full, q.size() == DEPTH);
    check("sticky_st", sticky_st, m_sticky);
    check("drop_err",  drop_err,  m_drop);
  endtask

  task automatic drive(input bit rv, input bit mode, input logic [127:0] d0,
                       input logic [127:0] d1, input logic [127:0] st,
                       input bit rdy, input bit clr, input bit r);
    res_valid = rv; res_mode = mode; res_dst0 = d0; res_dst1 = d1; res_st = st;
    wb_ready = rdy; sticky_clr = clr; rst = r;
    tick();
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, rdy, 0, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] held;

  initial begin
    drive(0, 0, '0, '0, '0, 0, 0, 1);
    drive(0, 0, '0, '0, '0, 0, 0, 1);
    check("rst_valid", wb_valid, 1'b0);
    check("rst_cnt",   fifo_cnt, 3'd0);

    // 1: single 32-bit result, lane status 3'b011 in every lane
    drive(1, 1, {4{32'h8000_0000}}, '0, {4{32'h0000_0003}}, 1, 0, 0);
    check("t1_no_early", wb_valid, 1'b0);
    idle(1, 1);
    check("t1_latency", wb_valid, 1'b1);
    check("t1_data", wb_data, {4{32'h8000_0000}});
    check("t1_sticky", sticky_st, 12'h6DB);
    idle(1, 2);

    // 2: single 4+8 result, two beats, sticky untouched
    drive(1, 0, {16{8'h11}}, {16{8'h22}}, {4{32'h7}}, 1, 0, 0);
    idle(1, 4);
    check("t2_sticky", sticky_st, 12'h6DB);

    // 3: backpressure until full, then one more result is dropped
    for (int i = 0; i < 6; i++) drive(1, 1, rnd128(), rnd128(), '0, 0, 0, 0);
    check("t3_full", fifo_full, 1'b1);
    check("t3_drop", drop_err, 1'b1);
    held = wb_data;
    idle(0, 3);
    check("t3_stable", wb_data, held);

    // 4: full FIFO, release and push at the same edge -> accepted
    drive(1, 1, rnd128(), rnd128(), '0, 1, 0, 0);
    check("t4_cnt", fifo_cnt, 3'd4);
    idle(1, 8);

    // 5: sticky clear with a concurrent 32-bit result (lane0 = 3'b100)
    drive(1, 1, rnd128(), rnd128(), 128'h4, 1, 1, 0);
    check("t5_sticky", sticky_st, 12'h004);
    check("t5_drop", drop_err, 1'b0);
    idle(1, 3);

    // 6: reset during beat 1 of a 4+8 entry with two entries queued
    for (int i = 0; i < 3; i++) drive(1, 0, rnd128(), rnd128(), '1, 0, 0, 0);
    idle(0, 1);
    idle(1, 1);
    check("t6_beat1", wb_beat, 1'b1);
    drive(0, 0, '0, '0, '0, 0, 0, 1);
    check("t6_valid", wb_valid, 1'b0);
    check("t6_cnt", fifo_cnt, 3'd0);
    check("t6_sticky", sticky_st, 12'h000);
    drive(1, 0, rnd128(), rnd128(), rnd128(), 1, 0, 0);
    idle(1, 4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 55, $urandom_range(0, 1), rnd128(), rnd128(), rnd128(),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3,
            $urandom_range(0, 399) == 0);
    end
    idle(1, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
